// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), the decoded-sync bundle and a
// constant-time clog2 helper used to size the position counters.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vga_sync_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing generator bundle: enable in, raw counters and delayed sync/enable strobes out.
interface vga_timing_gen_if #(
  parameter int CW_H = 10,
  parameter int CW_V = 10
) ();

  logic            enable;
  logic [CW_H-1:0] counterX;
  logic [CW_V-1:0] counterY;
  logic            hsync;
  logic            vsync;
  logic            inDisplayArea;
  logic            line_start;
  logic            frame_start;

  modport master (
    output enable,
    input  counterX, counterY, hsync, vsync, inDisplayArea, line_start, frame_start
  );

  modport slave (
    input  enable,
    output counterX, counterY, hsync, vsync, inDisplayArea, line_start, frame_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH 0 collapses to a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, enable};
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (enable) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running X/Y counters, one decode register, optional delay line,
// polarity applied last so reset leaves both syncs at their inactive level.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 0
) (
  input  logic           clk25MHz,
  input  logic           reset,
  vga_timing_gen_if.slave vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW_H    = clog2(H_TOTAL);
  localparam int CW_V    = clog2(V_TOTAL);

  localparam logic [CW_H-1:0] H_LAST   = CW_H'(H_TOTAL - 1);
  localparam logic [CW_H-1:0] H_ACT    = CW_H'(H_ACTIVE);
  localparam logic [CW_H-1:0] HS_FIRST = CW_H'(H_ACTIVE + H_FP);
  localparam logic [CW_H-1:0] HS_LAST  = CW_H'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW_V-1:0] V_LAST   = CW_V'(V_TOTAL - 1);
  localparam logic [CW_V-1:0] V_ACT    = CW_V'(V_ACTIVE);
  localparam logic [CW_V-1:0] VS_FIRST = CW_V'(V_ACTIVE + V_FP);
  localparam logic [CW_V-1:0] VS_LAST  = CW_V'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_params
      $error("vga_timing_gen: timing parameters must be non-zero and PIPE_DELAY 0..7");
    end
  endgenerate

  logic [CW_H-1:0] counter_x;
  logic [CW_V-1:0] counter_y;
  vga_sync_t       raw;
  vga_sync_t       dec_q;
  vga_sync_t       dly;

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      counter_x <= '0;
      counter_y <= '0;
    end else if (vga.enable) begin
      if (counter_x == H_LAST) begin
        counter_x <= '0;
        counter_y <= (counter_y == V_LAST) ? '0 : counter_y + 1'b1;
      end else begin
        counter_x <= counter_x + 1'b1;
      end
    end
  end

  always_comb begin
    raw             = '0;
    raw.hsync       = (counter_x >= HS_FIRST) && (counter_x <= HS_LAST);
    raw.vsync       = (counter_y >= VS_FIRST) && (counter_y <= VS_LAST);
    raw.de          = (counter_x < H_ACT) && (counter_y < V_ACT);
    raw.line_start  = (counter_x == '0);
    raw.frame_start = (counter_x == '0) && (counter_y == '0);
  end

  // Decode register adds the fixed one-clock lag; the delay line adds PIPE_DELAY more.
  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset)           dec_q <= '0;
    else if (vga.enable) dec_q <= raw;
  end

  vga_delay_line #(
    .WIDTH($bits(vga_sync_t)),
    .DEPTH(PIPE_DELAY)
  ) u_delay (
    .clk    (clk25MHz),
    .rst    (reset),
    .enable (vga.enable),
    .din    (dec_q),
    .dout   (dly)
  );

  assign vga.counterX      = counter_x;
  assign vga.counterY      = counter_y;
  assign vga.hsync         = dly.hsync ~^ HSYNC_POL;
  assign vga.vsync         = dly.vsync ~^ VSYNC_POL;
  assign vga.inDisplayArea = dly.de;
  assign vga.line_start    = dly.line_start;
  assign vga.frame_start   = dly.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny positive-polarity,
// PIPE_DELAY=3 instance, compared every clock against a queued reference model.
module tb_vga_timing_gen;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  always #20 clk = ~clk;

  vga_timing_gen_if #(.CW_H(10), .CW_V(10)) ifa ();
  vga_timing_gen_if #(.CW_H(4),  .CW_V(3))  ifb ();

  assign ifa.enable = enable;
  assign ifb.enable = enable;

  vga_timing_gen u_dut_a (
    .clk25MHz (clk),
    .reset    (reset),
    .vga      (ifa)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_dut_b (
    .clk25MHz (clk),
    .reset    (reset),
    .vga      (ifb)
  );

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int rel_cyc = 0;

  // reference model state and expectation scoreboards
  int         ax, ay, bx, by;
  logic [4:0] qa [$];
  logic [4:0] qb [$];
  logic [4:0] exp_a, exp_b;

  // measurements taken from observed waveforms
  int   a_ls_last = -1, a_ls_period = -1, a_ls_cnt = 0;
  int   a_x0 = -1, a_hs_fall = -1, a_hs_lag = -1, a_hs_width = -1;
  int   a_de_rise = -1, a_de_width = -1, a_fs_first = -1;
  int   b_ls_last = -1, b_ls_period = -1, b_fs_last = -1, b_fs_period = -1;
  int   b_xy0 = -1, b_fs_lag = -1, b_fs_first = -1;
  int   b_vs_rise = -1, b_vs_width = -1, b_hs_rise = -1, b_hs_width = -1, b_hs_rise_x = -1;
  logic a_ls_p, a_hs_p, a_de_p, a_fs_p, b_ls_p, b_fs_p, b_vs_p, b_hs_p;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] decode(input int x, input int y, input int ha, input int hf,
                                        input int hs, input int va, input int vf, input int vs);
    logic [4:0] r;
    r[4] = (x >= ha + hf) && (x < ha + hf + hs);
    r[3] = (y >= va + vf) && (y < va + vf + vs);
    r[2] = (x < ha) && (y < va);
    r[1] = (x == 0);
    r[0] = (x == 0) && (y == 0);
    return r;
  endfunction

  function automatic logic [31:0] pack(input int x, input int y, input int cwv,
                                       input logic [4:0] r, input bit hp, input bit vp);
    logic [4:0] o;
    o = {r[4] ~^ hp, r[3] ~^ vp, r[2:0]};
    return (32'(x) << (cwv + 5)) | (32'(y) << 5) | 32'(o);
  endfunction

  task automatic model_reset();
    ax = 0; ay = 0; bx = 0; by = 0;
    qa.delete();
    qb.delete();
    repeat (3) qb.push_back(5'b0);
    exp_a = '0;
    exp_b = '0;
  endtask

  task automatic model_advance();
    qa.push_back(decode(ax, ay, 640, 16, 96, 480, 10, 2));
    exp_a = qa.pop_front();
    ax++;
    if (ax == 800) begin
      ax = 0;
      ay = (ay == 524) ? 0 : ay + 1;
    end
    qb.push_back(decode(bx, by, 8, 2, 2, 4, 1, 1));
    exp_b = qb.pop_front();
    bx++;
    if (bx == 14) begin
      bx = 0;
      by = (by == 6) ? 0 : by + 1;
    end
  endtask

  task automatic compare_all();
    chk_eq("dut_a_outputs",
           32'({ifa.counterX, ifa.counterY, ifa.hsync, ifa.vsync, ifa.inDisplayArea,
                ifa.line_start, ifa.frame_start}),
           pack(ax, ay, 10, exp_a, 1'b0, 1'b0));
    chk_eq("dut_b_outputs",
           32'({ifb.counterX, ifb.counterY, ifb.hsync, ifb.vsync, ifb.inDisplayArea,
                ifb.line_start, ifb.frame_start}),
           pack(bx, by, 3, exp_b, 1'b1, 1'b1));
  endtask

  task automatic track_events();
    if (ifa.line_start && !a_ls_p) begin
      if (a_ls_last >= 0) a_ls_period = cyc - a_ls_last;
      a_ls_last = cyc;
      a_ls_cnt++;
    end
    if (!ifa.hsync && a_hs_p) begin
      a_hs_fall = cyc;
      if (a_x0 >= 0) a_hs_lag = cyc - a_x0;
    end
    if (ifa.hsync && !a_hs_p && a_hs_fall >= 0) a_hs_width = cyc - a_hs_fall;
    if (ifa.inDisplayArea && !a_de_p) a_de_rise = cyc;
    if (!ifa.inDisplayArea && a_de_p && a_de_rise >= 0) a_de_width = cyc - a_de_rise;
    if (ifa.frame_start && !a_fs_p && a_fs_first < 0) a_fs_first = cyc;
    if (ifa.counterX == 10'd0) a_x0 = cyc;

    if (ifb.line_start && !b_ls_p) begin
      if (b_ls_last >= 0) b_ls_period = cyc - b_ls_last;
      b_ls_last = cyc;
    end
    if (ifb.frame_start && !b_fs_p) begin
      if (b_fs_last >= 0) b_fs_period = cyc - b_fs_last;
      b_fs_last = cyc;
      if (b_xy0 >= 0) b_fs_lag = cyc - b_xy0;
      if (b_fs_first < 0) b_fs_first = cyc;
    end
    if (ifb.vsync && !b_vs_p) b_vs_rise = cyc;
    if (!ifb.vsync && b_vs_p && b_vs_rise >= 0) b_vs_width = cyc - b_vs_rise;
    if (ifb.hsync && !b_hs_p) begin
      b_hs_rise   = cyc;
      b_hs_rise_x = int'(ifb.counterX);
    end
    if (!ifb.hsync && b_hs_p && b_hs_rise >= 0) b_hs_width = cyc - b_hs_rise;
    if (ifb.counterX == 4'd0 && ifb.counterY == 3'd0) b_xy0 = cyc;

    a_ls_p = ifa.line_start;  a_hs_p = ifa.hsync;  a_de_p = ifa.inDisplayArea;
    a_fs_p = ifa.frame_start; b_ls_p = ifb.line_start; b_fs_p = ifb.frame_start;
    b_vs_p = ifb.vsync;       b_hs_p = ifb.hsync;
  endtask

  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    cyc++;
    #1;
    if (reset)   model_reset();
    else if (en) model_advance();
    compare_all();
    track_events();
  endtask

  task automatic release_reset();
    #10;
    reset      = 1'b0;
    rel_cyc    = cyc;
    a_fs_first = -1;
    b_fs_first = -1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    track_events();
    repeat (3) step(1'b0);
    release_reset();

    repeat (1700) step(1'b1);
    chk_eq("a_first_frame_start_lag", a_fs_first - rel_cyc, 1);
    chk_eq("b_first_frame_start_lag", b_fs_first - rel_cyc, 4);
    chk_eq("a_line_period",   a_ls_period, 800);
    chk_eq("a_hsync_fall_lag", a_hs_lag,   657);
    chk_eq("a_hsync_width",   a_hs_width,  96);
    chk_eq("a_de_width",      a_de_width,  640);
    chk_eq("b_line_period",   b_ls_period, 14);
    chk_eq("b_frame_period",  b_fs_period, 98);
    chk_eq("b_frame_start_lag", b_fs_lag,  4);
    chk_eq("b_vsync_width",   b_vs_width,  14);
    chk_eq("b_hsync_width",   b_hs_width,  2);
    chk_eq("b_hsync_rise_x",  b_hs_rise_x, 0);

    // mid-line stall of five clocks
    for (int i = 0; i < 1000 && ifa.counterX != 10'd300; i++) step(1'b1);
    chk_eq("a_reach_x300", 32'(ifa.counterX), 300);
    begin
      int ls_before;
      ls_before = a_ls_cnt;
      repeat (5) step(1'b0);
      for (int i = 0; i < 1000 && a_ls_cnt == ls_before; i++) step(1'b1);
      chk_eq("a_stall_line_period", a_ls_period, 805);
    end

    // asynchronous reset between edges
    for (int i = 0; i < 4000 && ifa.counterY != 10'd4; i++) step(1'b1);
    chk_eq("a_reach_y4", 32'(ifa.counterY), 4);
    #5;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    track_events();
    repeat (2) step(1'b1);
    release_reset();
    repeat (30) step(1'b1);
    chk_eq("a_rst_frame_start_lag", a_fs_first - rel_cyc, 1);
    chk_eq("b_rst_frame_start_lag", b_fs_first - rel_cyc, 4);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
